// File: rtl/fast_square_sweep_ctrl.sv
// Frequency-sweep sequencer for the fast-square subcarrier receiver: drives rx_reset,
// record and freq_step through settle/integrate/step/drain for each programmed step.
module fast_square_sweep_ctrl #(
    parameter int CTRLADDR          = 3,
    parameter int TIMINGADDR        = 4,
    parameter int RECORD_TICKS_LOG2 = 14,
    parameter int WORDS_PER_STEP    = 9,
    parameter int DRAIN_TIMEOUT     = 65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        serial_strobe,
    input  logic        data_out_strobe,
    output logic        rx_reset,
    output logic        record,
    output logic        freq_step,
    output logic        sweep_active,
    output logic [7:0]  step_index,
    output logic        sweep_done,
    output logic        overrun
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RXRST  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_RECORD = 3'd3;
    localparam logic [2:0] S_STEP   = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  drain_q, drain_d;
    logic [7:0]  step_q, step_d;
    logic [7:0]  nsteps_q, nsteps_d;
    logic        cont_q, cont_d;
    logic [15:0] settle_cfg_q, settle_cfg_d;
    logic [4:0]  log2_cfg_q, log2_cfg_d;
    logic [15:0] settle_q, settle_d;
    logic [4:0]  log2_q, log2_d;
    logic        overrun_q, overrun_d;
    logic        done_q, done_d;

    logic        ctrl_wr, timing_wr;
    logic        drain_done, timeout_hit, settle_end;
    logic [4:0]  log2_clamped;
    logic [16:0] rec_span;
    logic [15:0] rec_last;
    logic        unused_data;

    assign ctrl_wr   = serial_strobe && (serial_addr == 7'(CTRLADDR));
    assign timing_wr = serial_strobe && (serial_addr == 7'(TIMINGADDR));
    assign unused_data = ^{serial_data[31:21], serial_data[7:3]};

    assign log2_clamped = (log2_cfg_q > 5'(RECORD_TICKS_LOG2)) ? 5'(RECORD_TICKS_LOG2) : log2_cfg_q;
    assign rec_span     = 17'd1 << log2_q;
    assign rec_last     = 16'(rec_span - 17'd1);
    assign settle_end   = ({1'b0, cnt_q} + 17'd1) >= {1'b0, settle_q};

    // A completing strobe on the timeout cycle wins over the timeout.
    assign drain_done  = (state_q == S_DRAIN) && data_out_strobe &&
                         (drain_q == 4'(WORDS_PER_STEP - 1));
    assign timeout_hit = (state_q == S_DRAIN) && (cnt_q == 16'(DRAIN_TIMEOUT - 1)) && !drain_done;

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        nsteps_d     = nsteps_q;
        cont_d       = cont_q;
        settle_d     = settle_q;
        log2_d       = log2_q;
        settle_cfg_d = settle_cfg_q;
        log2_cfg_d   = log2_cfg_q;
        done_d       = 1'b0;
        overrun_d    = overrun_q;

        if (timing_wr) begin
            settle_cfg_d = serial_data[15:0];
            log2_cfg_d   = serial_data[20:16];
        end
        if (ctrl_wr && serial_data[2]) begin
            overrun_d = 1'b0;
        end
        if (timeout_hit) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (ctrl_wr && serial_data[0]) begin
                    nsteps_d = serial_data[15:8];
                    cont_d   = serial_data[1];
                    step_d   = 8'd0;
                    state_d  = S_RXRST;
                end
            end
            S_RXRST:  if (cnt_q == 16'd1) state_d = S_SETTLE;
            S_SETTLE: if (settle_end) state_d = S_RECORD;
            S_RECORD: if (cnt_q == rec_last) state_d = S_STEP;
            S_STEP:   state_d = S_DRAIN;
            S_DRAIN: begin
                if (drain_done || timeout_hit) begin
                    // num_steps of 0 wraps to 255 here, giving a 256-step sweep.
                    if (step_q != nsteps_q - 8'd1) begin
                        step_d  = step_q + 8'd1;
                        state_d = S_SETTLE;
                    end else begin
                        done_d  = 1'b1;
                        step_d  = 8'd0;
                        state_d = cont_q ? S_RXRST : S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ctrl_wr && !serial_data[0]) begin
            state_d = S_IDLE;
            step_d  = 8'd0;
            done_d  = 1'b0;
        end

        if ((state_d == S_RXRST) && (state_q != S_RXRST)) begin
            settle_d = settle_cfg_q;
            log2_d   = log2_clamped;
        end

        cnt_d   = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
        drain_d = ((state_q == S_DRAIN) && (state_d == S_DRAIN)) ?
                  drain_q + {3'b000, data_out_strobe} : 4'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 16'd0;
            drain_q      <= 4'd0;
            step_q       <= 8'd0;
            nsteps_q     <= 8'd0;
            cont_q       <= 1'b0;
            settle_cfg_q <= 16'd0;
            log2_cfg_q   <= 5'd0;
            settle_q     <= 16'd0;
            log2_q       <= 5'd0;
            overrun_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            drain_q      <= drain_d;
            step_q       <= step_d;
            nsteps_q     <= nsteps_d;
            cont_q       <= cont_d;
            settle_cfg_q <= settle_cfg_d;
            log2_cfg_q   <= log2_cfg_d;
            settle_q     <= settle_d;
            log2_q       <= log2_d;
            overrun_q    <= overrun_d;
            done_q       <= done_d;
        end
    end

    assign rx_reset     = (state_q == S_IDLE) || (state_q == S_RXRST);
    assign record       = (state_q == S_RECORD);
    assign freq_step    = (state_q == S_STEP);
    assign sweep_active = (state_q != S_IDLE);
    assign step_index   = step_q;
    assign sweep_done   = done_q;
    assign overrun      = overrun_q;

endmodule
